registrador_sequencia: RTL and testbench
========================================

// Module: registrador_sequencia
// PURPOSE
// - Parametrised sequence register bank: DEPTH entries of N bits, appended in order, read back via a pointer.
// - Stores the growing play sequence of the AstroGenius game.
//   The datapath appends one play per round and replays or checks from entry 0.
// - Generalises the single N-bit register to depth, with occupancy flags and pointer-based readout.
// PARAMETERS
// - N      default 4   data width per entry (>=1)
// - DEPTH  default 16  number of entries (>=2)
// - local AW = $clog2(DEPTH) pointer width; CW = $clog2(DEPTH+1) count width
// PORTS
// - clock         in   1      single clock; all state changes on posedge
// - clear_n       in   1      reset; asynchronous, active-low
// - sync_clear    in   1      synchronous empty of the bank
// - write_en      in   1      append D at index count
// - D             in   N      data to append
// - read_next     in   1      advance read pointer
// - read_restart  in   1      read pointer <= 0
// - cmp_en        in   1      compare request (see CONFIGURATION)
// - cmp_data      in   N      value compared against Q
// - Q             out  N      mem[rd_ptr], combinational from storage
// - rd_ptr        out  AW     current read index
// - count         out  CW     number of valid entries, 0..DEPTH
// - empty         out  1      count==0
// - full          out  1      count==DEPTH
// - read_end      out  1      count!=0 && rd_ptr==count-1
// - overflow      out  1      1-cycle pulse: write attempted while full
// - match         out  1      1-cycle pulse: compare hit
// - mismatch      out  1      1-cycle pulse: compare miss
// BEHAVIOUR
// - Reset (clear_n=0, async):
//   - all entries 0, count 0, rd_ptr 0.
//   - Outputs: Q=0, empty=1, full=0, read_end=0, overflow=match=mismatch=0.
//   - Reset mid-operation discards everything immediately.
// - Write:
//   - write_en & !full: mem[count]<=D, count<=count+1.
//   - write_en & full: no state change; overflow=1 for the next cycle.
// - Read pointer:
//   - Priority: sync_clear > read_restart > read_next.
//   - read_next when read_end or empty: rd_ptr holds (saturates, no wrap).
//   - Otherwise read_next increments rd_ptr.
// - sync_clear: count<=0, rd_ptr<=0; entries keep old data (unreachable); a same-cycle write is discarded.
// - Simultaneous write & read events:
//   - Both take effect.
//   - read_end/saturation use the pre-write count.
// - Q: combinational from mem[rd_ptr]; a write to index rd_ptr is visible on Q the cycle after the edge.
// - Flags empty/full/read_end: combinational from registered count/rd_ptr, valid the cycle after the update.
// - No wrap-around anywhere: count saturates at DEPTH; rd_ptr never exceeds count-1.
// - Latency: all registered effects appear 1 clock after the sampling edge.
// CONFIGURATION
// - Macro REGISTRADOR_SEQ_COMPARE_EN.
// - Defined:
//   - on posedge with cmp_en=1 and !empty: match<=(cmp_data==Q), mismatch<=(cmp_data!=Q).
//   - cmp_en while empty: both 0.
//   - Pulses last 1 cycle; compare does not move rd_ptr.
// - Undefined: no comparator logic; match=mismatch=0 constantly; cmp_en and cmp_data ignored.
// TESTING (N=4, DEPTH=4)
// - Reset, then write 3,5,9,C on consecutive cycles.
//   - Expect count 1..4; full=1 after the 4th write.
//   - Q=3 at rd_ptr 0, empty=0.
// - While full, write_en with D=F.
//   - Expect overflow=1 for 1 cycle, count stays 4, all entries unchanged.
// - Issue read_next x5.
//   - Expect Q=5,9,C,C,C and rd_ptr 1,2,3,3,3; read_end=1 from rd_ptr=3.
//   - Then read_restart gives Q=3.
// - Assert sync_clear together with write_en and read_next.
//   - Expect count=0, rd_ptr=0, empty=1.
//   - A following write of 7 gives Q=7.
// - Compare (macro defined), bank holds 3,5: cmp_data=3 at rd_ptr 0 -> match pulse.
//   - read_next, then cmp_data=3 -> mismatch pulse.
//   - With the macro undefined, both stay 0.
// - Reset mid-sequence: drop clear_n low between clock edges.
//   - Expect outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/registrador_sequencia.sv
// registrador_sequencia: append-only sequence register bank with pointer readout.
// Stores DEPTH entries of N bits for the game's growing play sequence.
// Entries are appended at index count and read back from mem[rd_ptr].
// Optional comparator enabled by defining REGISTRADOR_SEQ_COMPARE_EN;
// without it match/mismatch are tied low and cmp_en/cmp_data are ignored.
module registrador_sequencia #(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          clear_n,
    input  logic          sync_clear,
    input  logic          write_en,
    input  logic [N-1:0]  D,
    input  logic          read_next,
    input  logic          read_restart,
    input  logic          cmp_en,
    input  logic [N-1:0]  cmp_data,
    output logic [N-1:0]  Q,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          read_end,
    output logic          overflow,
    output logic          match,
    output logic          mismatch
);

    logic [N-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q;
    logic          wr_fire;

    // Flags derive from the registered count/pointer only
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign read_end = !empty && (CW'(rd_ptr_q) == count_q - CW'(1));
    assign Q        = mem_q[rd_ptr_q];
    assign rd_ptr   = rd_ptr_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    // Next count/pointer; pointer saturation is judged on the pre-write count
    always_comb begin
        wr_fire  = write_en && !full && !sync_clear;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        if (sync_clear)
            count_d = '0;
        else if (wr_fire)
            count_d = count_q + CW'(1);
        if (sync_clear || read_restart)
            rd_ptr_d = '0;
        else if (read_next && !empty && !read_end)
            rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // State registers and storage; reset wipes every entry
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= write_en && full;
            if (wr_fire) mem_q[count_q[AW-1:0]] <= D;
        end
    end

`ifdef REGISTRADOR_SEQ_COMPARE_EN
    logic match_q, mismatch_q;

    // Compare against the currently addressed entry; nothing reported while empty
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            match_q    <= cmp_en && !empty && (cmp_data == Q);
            mismatch_q <= cmp_en && !empty && (cmp_data != Q);
        end
    end

    assign match    = match_q;
    assign mismatch = mismatch_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^{cmp_en, cmp_data};
    assign match      = 1'b0;
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_registrador_sequencia.sv
// Directed bench for registrador_sequencia (N=4, DEPTH=4) with a behavioural
// model compared every cycle plus hand-computed literal expectations.
module tb_registrador_sequencia;

    localparam int N = 4;
    localparam int DEPTH = 4;
`ifdef REGISTRADOR_SEQ_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         clear_n, sync_clear, write_en, read_next, read_restart, cmp_en;
    logic [N-1:0] D, cmp_data, Q;
    logic [1:0]   rd_ptr;
    logic [2:0]   count;
    logic         empty, full, read_end, overflow, match, mismatch;

    int checks = 0;
    int errors = 0;

    registrador_sequencia #(.N(N), .DEPTH(DEPTH)) dut (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear),
        .write_en(write_en), .D(D), .read_next(read_next),
        .read_restart(read_restart), .cmp_en(cmp_en), .cmp_data(cmp_data),
        .Q(Q), .rd_ptr(rd_ptr), .count(count), .empty(empty), .full(full),
        .read_end(read_end), .overflow(overflow), .match(match), .mismatch(mismatch)
    );

    always #5 clock = ~clock;

    // Behavioural model: plain array + integer occupancy/pointer
    logic [N-1:0] m_mem [DEPTH];
    int  m_cnt, m_ptr;
    bit  m_ovf, m_mt, m_mm;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_cnt = 0; m_ptr = 0; m_ovf = 0; m_mt = 0; m_mm = 0;
        end else begin
            m_ovf = write_en && (m_cnt == DEPTH);
            m_mt  = CMP && cmp_en && (m_cnt != 0) && (cmp_data == m_mem[m_ptr]);
            m_mm  = CMP && cmp_en && (m_cnt != 0) && (cmp_data != m_mem[m_ptr]);
            if (sync_clear || read_restart) m_ptr = 0;
            else if (read_next && m_cnt != 0 && m_ptr < m_cnt - 1) m_ptr = m_ptr + 1;
            if (sync_clear) m_cnt = 0;
            else if (write_en && m_cnt < DEPTH) begin
                m_mem[m_cnt] = D;
                m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (clear_n) begin
            chk("m_Q", Q, m_mem[m_ptr]);
            chk("m_rd_ptr", rd_ptr, m_ptr);
            chk("m_count", count, m_cnt);
            chk("m_empty", empty, m_cnt == 0);
            chk("m_full", full, m_cnt == DEPTH);
            chk("m_read_end", read_end, (m_cnt != 0) && (m_ptr == m_cnt - 1));
            chk("m_overflow", overflow, m_ovf);
            chk("m_match", match, m_mt);
            chk("m_mismatch", mismatch, m_mm);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        sync_clear = 0; write_en = 0; read_next = 0; read_restart = 0; cmp_en = 0;
    endtask

    task automatic wr(input logic [N-1:0] v);
        write_en = 1; D = v; cyc(); write_en = 0;
    endtask

    logic [N-1:0] wvals [4];
    logic [N-1:0] rq    [5];
    int           rp    [5];

    initial begin
        wvals = '{4'h3, 4'h5, 4'h9, 4'hC};
        rq    = '{4'h5, 4'h9, 4'hC, 4'hC, 4'hC};
        rp    = '{1, 2, 3, 3, 3};
        clear_n = 0; D = 0; cmp_data = 0;
        idle();
        repeat (2) cyc();
        chk("rst_Q", Q, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_read_end", read_end, 0);
        chk("rst_pulses", {overflow, match, mismatch}, 0);
        clear_n = 1;
        cyc();

        // Fill the bank
        for (int i = 0; i < 4; i++) begin
            wr(wvals[i]);
            chk("fill_count", count, i + 1);
        end
        chk("fill_full", full, 1);
        chk("fill_Q", Q, 4'h3);
        chk("fill_empty", empty, 0);

        // Overflow attempt
        wr(4'hF);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 4);
        cyc();
        chk("ovf_end", overflow, 0);

        // Read walk with saturation
        for (int i = 0; i < 5; i++) begin
            read_next = 1; cyc(); read_next = 0;
            chk("walk_Q", Q, rq[i]);
            chk("walk_ptr", rd_ptr, rp[i]);
            chk("walk_end", read_end, rp[i] == 3);
        end
        read_restart = 1; cyc(); read_restart = 0;
        chk("restart_Q", Q, 4'h3);
        chk("restart_ptr", rd_ptr, 0);

        // sync_clear beats same-cycle write and read
        read_next = 1; cyc();
        sync_clear = 1; write_en = 1; D = 4'hA; cyc(); idle();
        chk("sclr_count", count, 0);
        chk("sclr_ptr", rd_ptr, 0);
        chk("sclr_empty", empty, 1);
        read_next = 1; cmp_en = 1; cmp_data = 4'h3; cyc(); idle();
        chk("empty_ptr", rd_ptr, 0);
        chk("empty_cmp", {match, mismatch}, 0);
        wr(4'h7);
        chk("after_clr_Q", Q, 4'h7);

        // Simultaneous write and read: saturation judged on the pre-write count
        write_en = 1; D = 4'h2; read_next = 1; cyc(); idle();
        chk("sim_ptr", rd_ptr, 0);
        chk("sim_count", count, 2);
        write_en = 1; D = 4'h4; read_next = 1; cyc(); idle();
        chk("sim2_ptr", rd_ptr, 1);
        chk("sim2_Q", Q, 4'h2);

        // Compare on bank 3,5
        sync_clear = 1; cyc(); idle();
        wr(4'h3); wr(4'h5);
        cmp_en = 1; cmp_data = 4'h3; cyc(); idle();
        chk("cmp_match", match, CMP);
        chk("cmp_match_mm", mismatch, 0);
        chk("cmp_ptr", rd_ptr, 0);
        cyc();
        chk("cmp_pulse_end", match, 0);
        read_next = 1; cyc(); idle();
        cmp_en = 1; cmp_data = 4'h3; cyc(); idle();
        chk("cmp_mismatch", mismatch, CMP);
        chk("cmp_mismatch_m", match, 0);

        // Asynchronous reset between edges
        wr(4'h9);
        #3;
        clear_n = 0;
        #1;
        chk("arst_Q", Q, 0);
        chk("arst_count", count, 0);
        chk("arst_ptr", rd_ptr, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_read_end", read_end, 0);
        chk("arst_pulses", {overflow, match, mismatch}, 0);
        cyc();
        clear_n = 1;
        wr(4'h6);
        chk("post_rst_Q", Q, 4'h6);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
